// File: rtl/mem_access_master_pkg.sv
// rtl/mem_access_master_pkg.sv - shared types and helpers for the load/store engine
// Size encodings, engine states and size-derived strobe/length helpers.
package mem_access_master_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_CAPTURE = 3'd2,
    ST_ISSUE   = 3'd3,
    RSP        = 3'd4
  } state_e;

  function automatic logic [3:0] strb_of_size(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // 33 bits so the range check against the limit can never wrap.
  function automatic logic [32:0] bytes_of_size(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 33'd1;
      SZ_HALF: return 33'd2;
      default: return 33'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_master_if.sv
// rtl/mem_access_master_if.sv - CPU request/response channel plus simple memory port
// The master modport is the engine's view; slave is the core/memory side.
interface mem_access_master_if;
  logic        iwReqValid;
  logic        owReqReady;
  logic        iwReqWrite;
  logic [1:0]  iwReqSize;
  logic        iwReqSigned;
  logic [31:0] iwReqAddr;
  logic [31:0] iwReqWdata;
  logic        owRspValid;
  logic [31:0] owRspData;
  logic        owRspFault;
  logic [31:0] owReadAddr;
  logic [31:0] owWriteAddr;
  logic [31:0] owWriteData;
  logic [3:0]  owWstrb;
  logic [31:0] iwReadData;

  modport master (
    input  iwReqValid, iwReqWrite, iwReqSize, iwReqSigned, iwReqAddr, iwReqWdata, iwReadData,
    output owReqReady, owRspValid, owRspData, owRspFault,
           owReadAddr, owWriteAddr, owWriteData, owWstrb
  );

  modport slave (
    output iwReqValid, iwReqWrite, iwReqSize, iwReqSigned, iwReqAddr, iwReqWdata, iwReadData,
    input  owReqReady, owRspValid, owRspData, owRspFault,
           owReadAddr, owWriteAddr, owWriteData, owWstrb
  );
endinterface

// File: rtl/mem_access_master_load_extend.sv
// rtl/mem_access_master_load_extend.sv - byte/half/word extraction with zero or sign extension
// Purely combinational so the fetch path can share it.
module load_extend
  import mem_access_master_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] ext_data
);

  always_comb begin
    ext_data = rdata;
    case (size)
      SZ_BYTE: ext_data = {{24{is_signed & rdata[7]}}, rdata[7:0]};
      SZ_HALF: ext_data = {{16{is_signed & rdata[15]}}, rdata[15:0]};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_master.sv
// rtl/mem_access_master.sv - single-outstanding load/store engine for the simple memory port
// Checks each request up front; faulting requests never touch the memory signals.
module mem_access_master
  import mem_access_master_pkg::*;
#(
  parameter logic [31:0] pLimitBytes = 32'd512,
  parameter bit          pCheckAlign = 1'b1
) (
  input  logic              iwClk,
  input  logic              iwnRst,
  mem_access_master_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        fault_q, fault_d;

  logic        req_fault;
  logic        misaligned;
  logic [32:0] req_end;
  logic [31:0] ext_data;

  load_extend u_load_extend (
    .rdata     (bus.iwReadData),
    .size      (size_q),
    .is_signed (signed_q),
    .ext_data  (ext_data)
  );

  always_comb begin
    misaligned = 1'b0;
    if (pCheckAlign) begin
      misaligned = ((bus.iwReqSize == SZ_HALF) && bus.iwReqAddr[0]) ||
                   ((bus.iwReqSize == SZ_WORD) && (bus.iwReqAddr[1:0] != 2'b00));
    end
    req_end   = {1'b0, bus.iwReqAddr} + bytes_of_size(bus.iwReqSize);
    req_fault = (bus.iwReqSize == SZ_BAD) || misaligned || (req_end > {1'b0, pLimitBytes});
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    signed_d   = signed_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    fault_d    = fault_q;
    case (state_q)
      IDLE: begin
        if (bus.iwReqValid) begin
          addr_d     = bus.iwReqAddr;
          size_d     = bus.iwReqSize;
          signed_d   = bus.iwReqSigned;
          wdata_d    = bus.iwReqWdata;
          rsp_data_d = 32'd0;
          fault_d    = req_fault;
          if (req_fault)           state_d = RSP;
          else if (bus.iwReqWrite) state_d = ST_ISSUE;
          else                     state_d = RD_ISSUE;
        end
      end
      RD_ISSUE:   state_d = RD_CAPTURE;
      RD_CAPTURE: begin
        rsp_data_d = ext_data;
        state_d    = RSP;
      end
      ST_ISSUE:   state_d = RSP;
      RSP:        state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      wdata_q    <= 32'd0;
      rsp_data_q <= 32'd0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      fault_q    <= fault_d;
    end
  end

  // Memory-side outputs decode straight from the state so a reset clears them without a clock.
  assign bus.owReqReady  = iwnRst && (state_q == IDLE);
  assign bus.owRspValid  = (state_q == RSP);
  assign bus.owRspFault  = fault_q && (state_q == RSP);
  assign bus.owRspData   = rsp_data_q;
  assign bus.owReadAddr  = (state_q == RD_ISSUE) ? addr_q  : 32'd0;
  assign bus.owWriteAddr = (state_q == ST_ISSUE) ? addr_q  : 32'd0;
  assign bus.owWriteData = (state_q == ST_ISSUE) ? wdata_q : 32'd0;
  assign bus.owWstrb     = (state_q == ST_ISSUE) ? strb_of_size(size_q) : 4'b0000;

endmodule
